// File: rtl/lfsr_pkg.sv
// Shared definitions for the LFSR-based memory BIST: widths, default seeds,
// feedback tap masks, pass length and the controller state encoding.
package lfsr_pkg;

  localparam int unsigned ADDR_W = 10;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned ERR_W  = 11;

  // One pass visits every nonzero address exactly once.
  localparam int unsigned PASS_LEN = 1023;

  localparam logic [ADDR_W-1:0] ADDR_SEED_DEF = 10'h3FF;
  localparam logic [DATA_W-1:0] DATA_SEED_DEF = 32'hACE10001;

  // Feedback taps as bit masks: x^10+x^7+1 -> bits 9,6;
  // x^32+x^22+x^2+x+1 -> bits 31,21,1,0.
  localparam logic [ADDR_W-1:0] ADDR_TAPS = 10'h240;
  localparam logic [DATA_W-1:0] DATA_TAPS = 32'h8020_0003;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WRITE,
    ST_READ,
    ST_DRAIN,
    ST_DONE
  } bist_state_e;

endpackage

// File: rtl/lfsr_gen.sv
// Parameterized Fibonacci LFSR. cur_o is the value consumed this cycle;
// load_i substitutes the seed for it, en_i advances past it. With both
// asserted the register steps from the seed, so a pass can restart at the
// seed without a bubble cycle.
module lfsr_gen #(
  parameter int unsigned      WIDTH = 8,
  parameter logic [WIDTH-1:0] TAPS  = '1,
  parameter logic [WIDTH-1:0] SEED  = {{(WIDTH-1){1'b0}}, 1'b1}
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en_i,
  input  logic             load_i,
  output logic [WIDTH-1:0] cur_o
);

  logic [WIDTH-1:0] lfsr_q, lfsr_d;

  assign cur_o = load_i ? SEED : lfsr_q;

  // Shift left, feedback is the XOR of the tapped bits of the current value.
  always_comb begin
    lfsr_d = lfsr_q;
    if (en_i)        lfsr_d = {cur_o[WIDTH-2:0], ^(cur_o & TAPS)};
    else if (load_i) lfsr_d = SEED;
  end

  // LFSR state register; reset puts it back at the seed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) lfsr_q <= SEED;
    else     lfsr_q <= lfsr_d;
  end

endmodule

// File: rtl/lfsr_bist_ctrl.sv
// Memory BIST controller: a write pass then a read/compare pass over a
// 1K x 32 single-port memory, addresses and data from two LFSRs.
// Optional macro LFSR_BIST_INVERT_PASS_EN adds a second write/read pair
// using inverted data.
module lfsr_bist_ctrl
  import lfsr_pkg::*;
#(
  parameter logic [ADDR_W-1:0] ADDR_SEED = ADDR_SEED_DEF,
  parameter logic [DATA_W-1:0] DATA_SEED = DATA_SEED_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [ERR_W-1:0]  err_count,
  output logic [ADDR_W-1:0] first_fail_addr,
  output logic              mem_we,
  output logic              mem_re,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam logic [ADDR_W-1:0] LAST_STEP = ADDR_W'(PASS_LEN - 1);

  bist_state_e       state_q;
  logic [ADDR_W-1:0] step_q;
  logic              inv_q;
  logic              busy_q, done_q, pass_q, we_q, re_q;
  logic [ERR_W-1:0]  err_q;
  logic [ADDR_W-1:0] ffa_q, addr_q, cmp_addr_q;
  logic [DATA_W-1:0] wdata_q, exp_q, cmp_exp_q;
  logic              cmp_vld_q;

  logic              kick, active, last, more;
  logic              issue, reload, next_we, next_inv, miss;
  logic [ADDR_W-1:0] a_cur;
  logic [DATA_W-1:0] d_cur, d_pat;

  lfsr_gen #(.WIDTH(ADDR_W), .TAPS(ADDR_TAPS), .SEED(ADDR_SEED)) u_addr_lfsr (
    .clk    (clk),
    .rst    (rst),
    .en_i   (issue),
    .load_i (reload),
    .cur_o  (a_cur)
  );

  lfsr_gen #(.WIDTH(DATA_W), .TAPS(DATA_TAPS), .SEED(DATA_SEED)) u_data_lfsr (
    .clk    (clk),
    .rst    (rst),
    .en_i   (issue),
    .load_i (reload),
    .cur_o  (d_cur)
  );

  // Decide whether an access goes out next cycle, of which kind, and whether
  // the LFSRs restart at their seeds for it.
  always_comb begin
    kick   = (state_q == ST_IDLE || state_q == ST_DONE) && start;
    active = (state_q == ST_WRITE || state_q == ST_READ) && !abort;
    last   = (step_q == LAST_STEP);
`ifdef LFSR_BIST_INVERT_PASS_EN
    more   = !inv_q;
`else
    more   = 1'b0;
`endif
    issue    = kick;
    reload   = kick;
    next_we  = 1'b1;
    next_inv = 1'b0;
    if (active) begin
      if (state_q == ST_WRITE) begin
        issue    = 1'b1;
        reload   = last;
        next_we  = !last;
        next_inv = inv_q;
      end else begin
        issue    = !last || more;
        reload   = last && more;
        next_we  = last;
        next_inv = last ? 1'b1 : inv_q;
      end
    end
    d_pat = next_inv ? ~d_cur : d_cur;
    miss  = cmp_vld_q && (mem_rdata != cmp_exp_q);
  end

  // Controller FSM with registered strobes, compare pipeline and result regs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      step_q     <= '0;
      inv_q      <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      pass_q     <= 1'b0;
      we_q       <= 1'b0;
      re_q       <= 1'b0;
      err_q      <= '0;
      ffa_q      <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      exp_q      <= '0;
      cmp_vld_q  <= 1'b0;
      cmp_addr_q <= '0;
      cmp_exp_q  <= '0;
    end else begin
      done_q     <= 1'b0;
      we_q       <= 1'b0;
      re_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      // Read data returns one cycle after mem_re, so the compare trails it.
      cmp_vld_q  <= re_q;
      cmp_addr_q <= addr_q;
      cmp_exp_q  <= exp_q;
      if (miss) begin
        err_q <= err_q + ERR_W'(1);
        if (err_q == '0) ffa_q <= cmp_addr_q;
      end
      if (issue) begin
        we_q    <= next_we;
        re_q    <= !next_we;
        addr_q  <= a_cur;
        wdata_q <= next_we ? d_pat : '0;
        exp_q   <= d_pat;
      end
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            state_q   <= ST_WRITE;
            step_q    <= '0;
            inv_q     <= 1'b0;
            busy_q    <= 1'b1;
            pass_q    <= 1'b0;
            err_q     <= '0;
            ffa_q     <= '0;
            cmp_vld_q <= 1'b0;
          end
        end
        ST_WRITE, ST_READ, ST_DRAIN: begin
          if (abort) begin
            // Drop everything; results so far stay visible but never pass.
            state_q   <= ST_IDLE;
            busy_q    <= 1'b0;
            pass_q    <= 1'b0;
            err_q     <= err_q;
            ffa_q     <= ffa_q;
            cmp_vld_q <= 1'b0;
          end else if (state_q == ST_DRAIN) begin
            state_q <= ST_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            pass_q  <= (err_q == '0) && !miss;
          end else begin
            step_q <= last ? '0 : step_q + ADDR_W'(1);
            if (last) begin
              if (state_q == ST_WRITE) begin
                state_q <= ST_READ;
              end else if (more) begin
                state_q <= ST_WRITE;
                inv_q   <= 1'b1;
              end else begin
                state_q <= ST_DRAIN;
              end
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign busy            = busy_q;
  assign done            = done_q;
  assign pass            = pass_q;
  assign err_count       = err_q;
  assign first_fail_addr = ffa_q;
  assign mem_we          = we_q;
  assign mem_re          = re_q;
  assign mem_addr        = addr_q;
  assign mem_wdata       = wdata_q;

endmodule

// File: tb/tb_lfsr_bist_ctrl.sv
// Self-checking bench for lfsr_bist_ctrl: memory model with injectable
// read-back faults and a pass-level reference model of the expected results.
module tb_lfsr_bist_ctrl;

  localparam logic [9:0]  ASEED = 10'h3FF;
  localparam logic [31:0] DSEED = 32'hACE10001;
`ifdef LFSR_BIST_INVERT_PASS_EN
  localparam int NPASS = 2;
`else
  localparam int NPASS = 1;
`endif
  localparam int BUSY_CYC = NPASS * 2046 + 1;
  localparam int LIMIT    = 6000;

  logic        clk = 1'b0, rst = 1'b1, start = 1'b0, abort = 1'b0;
  logic        busy, done, pass, mem_we, mem_re;
  logic [10:0] err_count;
  logic [9:0]  first_fail_addr, mem_addr;
  logic [31:0] mem_wdata, mem_rdata;

  always #5 clk = ~clk;

  lfsr_bist_ctrl dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .busy(busy), .done(done), .pass(pass), .err_count(err_count),
    .first_fail_addr(first_fail_addr), .mem_we(mem_we), .mem_re(mem_re),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  // Memory with XOR-flip and stuck-at-1 faults applied on read-back.
  logic [31:0] mem  [1024];
  logic [31:0] flip [1024];
  logic [31:0] stuck;
  always @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_wdata;
    if (mem_re) mem_rdata <= (mem[mem_addr] ^ flip[mem_addr]) | stuck;
  end

  // Activity monitor.
  int nb, nd, ov, nw;
  logic [9:0]  wa0, wa1;
  logic [31:0] wd0, wd1, inv_wd;
  logic mon_clr = 1'b0;
  always @(negedge clk) begin
    if (mon_clr) begin
      nb = 0; nd = 0; ov = 0; nw = 0; inv_wd = '0;
    end else begin
      if (busy) nb++;
      if (done) nd++;
      if (mem_we && mem_re) ov++;
      if (mem_we) begin
        if (nw == 0) begin wa0 = mem_addr; wd0 = mem_wdata; end
        if (nw == 1) begin wa1 = mem_addr; wd1 = mem_wdata; end
        if (nw == 1023) inv_wd = mem_wdata;
        nw++;
      end
    end
  end

  int tests = 0, fails = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // Reference: each pass walks the address/data sequences from the seeds;
  // the second pass (if any) expects inverted data. A word fails when the
  // faulted read-back differs from what was written.
  function automatic void model(output int errs, output logic [9:0] ffa);
    logic [9:0]  a;
    logic [31:0] d, e, got;
    errs = 0; ffa = '0;
    for (int p = 0; p < NPASS; p++) begin
      a = ASEED; d = DSEED;
      for (int i = 0; i < 1023; i++) begin
        e   = (p == 1) ? ~d : d;
        got = (e ^ flip[a]) | stuck;
        if (got !== e) begin
          if (errs == 0) ffa = a;
          errs++;
        end
        a = {a[8:0], a[9] ^ a[6]};
        d = {d[30:0], d[31] ^ d[21] ^ d[1] ^ d[0]};
      end
    end
  endfunction

  // Start a test and follow it until done, abort, reset or the cycle budget.
  task automatic run_test(input int abort_at, input int restart_at, input int rst_at,
                          output int cyc);
    mon_clr = 1'b1; tick(); mon_clr = 1'b0;
    repeat ($urandom_range(0, 3)) tick();
    start = 1'b1; tick(); start = 1'b0;
    cyc = 1;
    while (cyc < LIMIT) begin
      if (cyc == rst_at) begin rst = 1'b1; #1; return; end
      abort = (cyc == abort_at);
      start = (cyc == restart_at);
      tick();
      abort = 1'b0; start = 1'b0;
      if (cyc == abort_at) return;
      if (done) return;
      cyc++;
    end
  endtask

  task automatic check_done(input string tag, input int cyc);
    int e;
    logic [9:0] f;
    model(e, f);
    chk({tag, " in_time"}, 64'(cyc < LIMIT), 64'd1);
    chk({tag, " err_count"}, 64'(err_count), 64'(e));
    chk({tag, " first_fail"}, 64'(first_fail_addr), 64'(f));
    chk({tag, " pass"}, 64'(pass), 64'(e == 0));
    tick();
    chk({tag, " done_1cyc"}, 64'(done), 64'd0);
    chk({tag, " pass_hold"}, 64'(pass), 64'(e == 0));
    @(negedge clk); #1;
    chk({tag, " busy_cycles"}, 64'(nb), 64'(BUSY_CYC));
    chk({tag, " done_pulses"}, 64'(nd), 64'd1);
    chk({tag, " we_re_overlap"}, 64'(ov), 64'd0);
    tick();
  endtask

  task automatic check_idle_outputs(input string tag);
    chk({tag, " busy"}, 64'(busy), 64'd0);
    chk({tag, " done"}, 64'(done), 64'd0);
    chk({tag, " pass"}, 64'(pass), 64'd0);
    chk({tag, " err"}, 64'(err_count), 64'd0);
    chk({tag, " ffa"}, 64'(first_fail_addr), 64'd0);
    chk({tag, " we"}, 64'(mem_we), 64'd0);
    chk({tag, " re"}, 64'(mem_re), 64'd0);
    chk({tag, " addr"}, 64'(mem_addr), 64'd0);
    chk({tag, " wdata"}, 64'(mem_wdata), 64'd0);
  endtask

  initial begin
    int cyc, n;
    logic [9:0] fa;
    logic [31:0] fm;
    for (int i = 0; i < 1024; i++) begin flip[i] = '0; mem[i] = '0; end
    stuck = '0;

    // Reset state.
    repeat (3) tick();
    check_idle_outputs("reset");
    rst = 1'b0;
    repeat (2) tick();
    chk("post_reset busy", 64'(busy), 64'd0);

    // Clean run with ideal memory.
    run_test(0, 0, 0, cyc);
    check_done("clean", cyc);
    chk("first_write addr", 64'(wa0), 64'(10'h3FF));
    chk("first_write data", 64'(wd0), 64'(32'hACE10001));
    chk("second_write addr", 64'(wa1), 64'(10'h3FE));
    chk("second_write data", 64'(wd1), 64'(32'h59C20003));
`ifdef LFSR_BIST_INVERT_PASS_EN
    chk("first_inv_write data", 64'(inv_wd), 64'(32'h531EFFFE));
`endif

    // Bit 0 flipped on read-back of 3FE; start issued from DONE.
    flip[10'h3FE] = 32'h1;
    run_test(0, 0, 0, cyc);
    check_done("flip3fe", cyc);
    chk("flip3fe ffa_const", 64'(first_fail_addr), 64'(10'h3FE));

    // Rerun from DONE with the fault removed: results clear.
    flip[10'h3FE] = '0;
    run_test(0, 0, 0, cyc);
    check_done("rerun_clean", cyc);

    // Random fault sets.
    for (int r = 0; r < 3; r++) begin
      n = $urandom_range(1, 6);
      for (int k = 0; k < n; k++) begin
        fa = 10'($urandom_range(1, 1023));
        fm = $urandom;
        if (fm == 0) fm = 32'h8;
        flip[fa] = fm;
      end
      run_test(0, 0, 0, cyc);
      check_done($sformatf("rand%0d", r), cyc);
      for (int i = 0; i < 1024; i++) flip[i] = '0;
    end

    // Abort on the 500th write cycle.
    run_test(500, 0, 0, cyc);
    chk("abort_w busy", 64'(busy), 64'd0);
    chk("abort_w we", 64'(mem_we), 64'd0);
    chk("abort_w re", 64'(mem_re), 64'd0);
    chk("abort_w pass", 64'(pass), 64'd0);
    repeat (5) tick();
    chk("abort_w no_done", 64'(nd), 64'd0);
    run_test(0, 0, 0, cyc);
    check_done("after_abort", cyc);

    // Abort during the read pass after a miscompare: error state holds.
    flip[10'h3FE] = 32'h1;
    run_test(1023 + 600, 0, 0, cyc);
    chk("abort_r busy", 64'(busy), 64'd0);
    chk("abort_r re", 64'(mem_re), 64'd0);
    chk("abort_r err_hold", 64'(err_count), 64'd1);
    chk("abort_r ffa_hold", 64'(first_fail_addr), 64'(10'h3FE));
    chk("abort_r pass", 64'(pass), 64'd0);
    repeat (3) tick();
    chk("abort_r no_done", 64'(nd), 64'd0);
    flip[10'h3FE] = '0;

    // Second start while busy is ignored.
    run_test(0, 1500, 0, cyc);
    check_done("restart_busy", cyc);

    // Reset during READ after an error was counted.
    flip[10'h3FE] = 32'h1;
    run_test(0, 0, 1500, cyc);
    check_idle_outputs("mid_reset");
    tick();
    rst = 1'b0;
    flip[10'h3FE] = '0;
    tick();
    run_test(0, 0, 0, cyc);
    check_done("after_reset", cyc);
    chk("after_reset addr_seed", 64'(wa0), 64'(ASEED));
    chk("after_reset data_seed", 64'(wd0), 64'(DSEED));

    // Stuck-at-1 on bit 31.
    stuck = 32'h8000_0000;
    run_test(0, 0, 0, cyc);
    check_done("stuck31", cyc);
    stuck = '0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
